// File: rtl/vga_capture.sv
// VGA link sink: registers the pins, recovers pixel coordinates, measures line/frame lengths and declares lock.
// Define VGA_CAPTURE_CHECKSUM_EN to add a per-frame rotating checksum (frame_csum / csum_valid).
module vga_capture #(
    parameter int H_VISIBLE   = 640,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int H_TOTAL     = 800,
    parameter int V_VISIBLE   = 480,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk_25_175,
    input  logic        rst_n,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [3:0]  r,
    input  logic [3:0]  g,
    input  logic [3:0]  b,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [11:0] pix_rgb,
    output logic        frame_start,
    output logic        locked,
    output logic        timing_err,
    output logic [11:0] h_meas,
    output logic [10:0] v_meas
`ifdef VGA_CAPTURE_CHECKSUM_EN
    ,
    output logic [15:0] frame_csum,
    output logic        csum_valid
`endif
);

    localparam logic [11:0] X_FIRST = 12'(H_SYNC + H_BP);
    localparam logic [11:0] X_END   = 12'(H_SYNC + H_BP + H_VISIBLE);
    localparam logic [10:0] Y_FIRST = 11'(V_SYNC + V_BP);
    localparam logic [10:0] Y_END   = 11'(V_SYNC + V_BP + V_VISIBLE);
    localparam logic [11:0] H_TOT   = 12'(H_TOTAL);
    localparam logic [10:0] V_TOT   = 11'(V_TOTAL);
    localparam int          GW      = (LOCK_FRAMES > 1) ? $clog2(LOCK_FRAMES) : 1;
    localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_FRAMES - 1);

    typedef enum logic [1:0] {SEARCH, SYNCING, LOCKED} state_t;

    state_t        state, state_nxt;
    logic [GW-1:0] good_cnt, good_nxt;

    logic        hs_r, hs_d, vs_r, vs_d;
    logic [11:0] rgb_r;
    logic        hs_fall, vs_fall;
    logic [11:0] h_cnt;
    logic [10:0] v_cnt, v_cnt_inc;
    logic        h_seen, v_seen;
    logic        h_bad, v_bad, err_now;
    logic        in_win;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // Sync registers reset to 0: an idle-high line at release gives a rising edge, which is ignored.
    always_ff @(posedge clk_25_175 or negedge rst_n) begin
        if (!rst_n) begin
            hs_r  <= 1'b0;
            hs_d  <= 1'b0;
            vs_r  <= 1'b0;
            vs_d  <= 1'b0;
            rgb_r <= '0;
        end else begin
            hs_r  <= hsync;
            hs_d  <= hs_r;
            vs_r  <= vsync;
            vs_d  <= vs_r;
            rgb_r <= {r, g, b};
        end
    end

    assign hs_fall = hs_d & ~hs_r;
    assign vs_fall = vs_d & ~vs_r;

    // A coincident hsync is included in the frame's line count before v_cnt restarts at 0.
    assign v_cnt_inc = (hs_fall && v_cnt != 11'h7FF) ? v_cnt + 11'd1 : v_cnt;
    assign h_bad     = hs_fall && h_seen && (h_cnt != H_TOT);
    assign v_bad     = vs_fall && v_seen && (v_cnt_inc != V_TOT);
    assign err_now   = (h_bad || v_bad) && (state != SEARCH);

    always_ff @(posedge clk_25_175 or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            h_seen      <= 1'b0;
            v_seen      <= 1'b0;
            h_meas      <= '0;
            v_meas      <= '0;
            frame_start <= 1'b0;
            timing_err  <= 1'b0;
        end else begin
            frame_start <= vs_fall;
            timing_err  <= err_now;
            if (hs_fall) begin
                h_cnt  <= 12'd1;
                h_seen <= 1'b1;
                if (h_seen) h_meas <= h_cnt;
            end else if (h_cnt != 12'hFFF) begin
                h_cnt <= h_cnt + 12'd1;
            end
            if (vs_fall) begin
                v_cnt  <= '0;
                v_seen <= 1'b1;
                if (v_seen) v_meas <= v_cnt_inc;
            end else begin
                v_cnt <= v_cnt_inc;
            end
        end
    end

    always_ff @(posedge clk_25_175 or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SEARCH;
            good_cnt <= '0;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        case (state)
            SEARCH: begin
                if (vs_fall) begin
                    state_nxt = SYNCING;
                    good_nxt  = '0;
                end
            end
            SYNCING: begin
                if (err_now) begin
                    state_nxt = SEARCH;
                    good_nxt  = '0;
                end else if (vs_fall) begin
                    if (good_cnt == GOOD_LAST) begin
                        state_nxt = LOCKED;
                        good_nxt  = '0;
                    end else begin
                        good_nxt = good_cnt + GW'(1);
                    end
                end
            end
            LOCKED: begin
                if (err_now) state_nxt = SEARCH;
            end
            default: state_nxt = SEARCH;
        endcase
    end

    assign locked = (state == LOCKED);

    // h_cnt/v_cnt and rgb_r are aligned: both reflect the pin sample taken at the last edge.
    assign in_win = (h_cnt >= X_FIRST) && (h_cnt < X_END) &&
                    (v_cnt >= Y_FIRST) && (v_cnt < Y_END);

    always_ff @(posedge clk_25_175 or negedge rst_n) begin
        if (!rst_n) begin
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_rgb   <= '0;
        end else begin
            pix_valid <= locked && in_win;
            if (locked && in_win) begin
                pix_x   <= 10'(h_cnt - X_FIRST);
                pix_y   <= 10'(v_cnt - Y_FIRST);
                pix_rgb <= rgb_r;
            end
        end
    end

`ifdef VGA_CAPTURE_CHECKSUM_EN
    logic [15:0] csum;

    // Cleared on every vsync so a frame cut short by a lock loss never leaks into a later capture.
    always_ff @(posedge clk_25_175 or negedge rst_n) begin
        if (!rst_n) begin
            csum       <= '0;
            frame_csum <= '0;
            csum_valid <= 1'b0;
        end else begin
            csum_valid <= 1'b0;
            if (vs_fall) begin
                if (locked) begin
                    frame_csum <= csum;
                    csum_valid <= 1'b1;
                end
                csum <= '0;
            end else if (pix_valid) begin
                csum <= {csum[14:0], csum[15]} ^ {4'h0, pix_rgb};
            end
        end
    end
`endif

endmodule
